// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   DATA_BITS      - payload bits per frame
//   OVERSAMPLE_DEF - default baudclk cycles per bit
//   uart_state_t   - receiver frame-tracking states
package uart_pkg;
  localparam int DATA_BITS      = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: STAGES-deep flop chain that brings the asynchronous serial
// line into the baudclk domain. Reset loads 1s so the line reads idle.
//   baudclk  in   sample clock
//   reset_n  in   synchronous active-low reset
//   din      in   raw serial line
//   dout     out  synchronized line
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic baudclk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge baudclk) begin
    if (!reset_n) sr <= '1;
    else          sr <= {sr[STAGES-2:0], din};
  end

  assign dout = sr[STAGES-1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receiver, 8N1 by default (8E1 when
// UART_RX_PARITY_EN is defined). Recovers one byte per frame.
//   baudclk     in   sample clock, OVERSAMPLE x baud rate
//   reset_n     in   synchronous active-low reset
//   UART_RX     in   serial line, idle high, asynchronous
//   RX_DATA     out  last good byte, held until the next good frame
//   RX_STATUS   out  one-cycle pulse when RX_DATA takes a new good byte
//   FRAME_ERR   out  one-cycle pulse when the stop bit samples low
//   RX_BUSY     out  high from start detection until back in IDLE
//   PARITY_ERR  out  (UART_RX_PARITY_EN only) one-cycle pulse on bad even parity
// Timing: if the FSM first sees the synchronized line low at edge t,
// RX_STATUS is registered at edge t + OVERSAMPLE/2 + 9*OVERSAMPLE
// (+OVERSAMPLE with parity).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 baudclk,
  input  logic                 reset_n,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_STATUS,
  output logic                 FRAME_ERR,
`ifdef UART_RX_PARITY_EN
  output logic                 PARITY_ERR,
`endif
  output logic                 RX_BUSY
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rxs;
  uart_state_t          state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .baudclk (baudclk),
    .reset_n (reset_n),
    .din     (UART_RX),
    .dout    (rxs)
  );

  always_ff @(posedge baudclk) begin
    if (!reset_n) begin
      state     <= IDLE;
      tick      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      RX_DATA   <= '0;
      RX_STATUS <= 1'b0;
      FRAME_ERR <= 1'b0;
      RX_BUSY   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PARITY_ERR <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      RX_STATUS <= 1'b0;
      FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PARITY_ERR <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            tick    <= '0;
            RX_BUSY <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject glitches.
        START: begin
          if (tick == HALF_M1) begin
            tick <= '0;
            if (rxs) begin
              state   <= IDLE;
              RX_BUSY <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        // Tick is phase-aligned to mid-bit, so a full wrap lands mid next bit.
        DATA: begin
          if (tick == FULL_M1) begin
            tick           <= '0;
            shreg[bit_idx] <= rxs;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: data and parity bit together must XOR to 0.
        PARITY: begin
          if (tick == FULL_M1) begin
            tick    <= '0;
            par_bad <= ^{shreg, rxs};
            state   <= STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
`endif

        // Leave immediately after the mid-stop sample so a following start
        // edge half a bit later is still caught.
        STOP: begin
          if (tick == FULL_M1) begin
            tick <= '0;
            if (rxs) begin
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                PARITY_ERR <= 1'b1;
              end else begin
                RX_DATA   <= shreg;
                RX_STATUS <= 1'b1;
              end
`else
              RX_DATA   <= shreg;
              RX_STATUS <= 1'b1;
`endif
              state   <= IDLE;
              RX_BUSY <= 1'b0;
            end else begin
              FRAME_ERR <= 1'b1;
`ifdef UART_RX_PARITY_EN
              PARITY_ERR <= par_bad;
`endif
              state <= BREAK;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        // A held-low line reports one error only; wait for it to go idle.
        BREAK: begin
          if (rxs) begin
            state   <= IDLE;
            RX_BUSY <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          RX_BUSY <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against a frame-level expectation model.
// Each frame task schedules the cycle at which a status/error pulse must
// appear and the byte it carries; a per-cycle compare checks every output.
module tb_uart_receiver;
  localparam int OS  = 16;
  localparam int SS  = 2;
  localparam int DET = SS + 1;               // line driven after edge N -> seen by FSM at N+DET
`ifdef UART_RX_PARITY_EN
  localparam int LAT = OS/2 + 10*OS;
`else
  localparam int LAT = OS/2 + 9*OS;
`endif

  logic       baudclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       UART_RX = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_STATUS, FRAME_ERR, RX_BUSY;
`ifdef UART_RX_PARITY_EN
  logic       PARITY_ERR;
`endif

  uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(SS)) dut (
    .baudclk   (baudclk),
    .reset_n   (reset_n),
    .UART_RX   (UART_RX),
    .RX_DATA   (RX_DATA),
    .RX_STATUS (RX_STATUS),
    .FRAME_ERR (FRAME_ERR),
`ifdef UART_RX_PARITY_EN
    .PARITY_ERR(PARITY_ERR),
`endif
    .RX_BUSY   (RX_BUSY)
  );

  always #5 baudclk = ~baudclk;

  int   cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge baudclk) begin
    cyc   <= cyc + 1;
    rst_q <= reset_n;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Expectation model: cycle -> event
  logic [7:0] exp_stat [int];
  bit         exp_ferr [int];
  bit         exp_perr [int];
  logic [7:0] model_data = 8'h00;

  always @(negedge baudclk) begin : cmp
    bit es, ef;
    if (!rst_q) begin
      model_data = 8'h00;
      chk("rst_rx_data", RX_DATA, 0);
      chk("rst_rx_status", RX_STATUS, 0);
      chk("rst_frame_err", FRAME_ERR, 0);
      chk("rst_rx_busy", RX_BUSY, 0);
    end else begin
      es = exp_stat.exists(cyc);
      ef = exp_ferr.exists(cyc);
      if (es) model_data = exp_stat[cyc];
      chk("rx_status", RX_STATUS, es);
      chk("frame_err", FRAME_ERR, ef);
      chk("rx_data", RX_DATA, model_data);
`ifdef UART_RX_PARITY_EN
      chk("parity_err", PARITY_ERR, exp_perr.exists(cyc));
`endif
    end
  end

  // Event monitor for literal spot checks
  bit         busy_prev = 1'b0;
  int         busy_rise = 0, stat_at = 0, n_stat = 0, n_ferr = 0;
  logic [7:0] got [$];
  always @(negedge baudclk) begin
    if (RX_BUSY === 1'b1 && !busy_prev) busy_rise = cyc;
    busy_prev = (RX_BUSY === 1'b1);
    if (RX_STATUS === 1'b1) begin
      stat_at = cyc;
      n_stat++;
      got.push_back(RX_DATA);
    end
    if (FRAME_ERR === 1'b1) n_ferr++;
  end

  task automatic align();
    @(posedge baudclk); #1;
  endtask

  task automatic drive_bit(input logic v);
    UART_RX = v;
    repeat (OS) @(posedge baudclk);
    #1;
  endtask

  // par_flip inverts the even-parity bit (parity builds only).
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    int t;
    t = cyc + DET + LAT;
    if (!stop_v) exp_ferr[t] = 1'b1;
`ifdef UART_RX_PARITY_EN
    if (par_flip) exp_perr[t] = 1'b1;
    if (stop_v && !par_flip) exp_stat[t] = d;
`else
    if (stop_v) exp_stat[t] = d;
`endif
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_v);
  endtask

  initial begin
    logic [7:0] b5a;
    int k;
    b5a = 8'h5A;
    reset_n = 1'b0;
    UART_RX = 1'b1;
    repeat (4) @(posedge baudclk);
    #1;
    chk("reset_data", RX_DATA, 8'h00);
    chk("reset_status", RX_STATUS, 0);
    chk("reset_ferr", FRAME_ERR, 0);
    chk("reset_busy", RX_BUSY, 0);
    reset_n = 1'b1;
    repeat (OS) align();

    // Single frame, latency pinned by hand
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (2*OS) align();
    chk("a5_data", RX_DATA, 8'hA5);
`ifdef UART_RX_PARITY_EN
    chk("a5_latency", stat_at - busy_rise, 168);
`else
    chk("a5_latency", stat_at - busy_rise, 152);
`endif
    chk("a5_pulses", n_stat, 1);
    chk("a5_no_ferr", n_ferr, 0);

    // Back-to-back frames, one stop bit
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (2*OS) align();
    chk("b2b_pulses", n_stat, 3);
    chk("b2b_first", got[1], 8'h00);
    chk("b2b_second", got[2], 8'hFF);
    chk("b2b_data", RX_DATA, 8'hFF);

    // 3-cycle glitch: busy briefly, no pulses
    UART_RX = 1'b0;
    repeat (3) align();
    UART_RX = 1'b1;
    k = 0;
    while (RX_BUSY !== 1'b1 && k < 10) begin @(negedge baudclk); k++; end
    chk("glitch_busy_hi", RX_BUSY, 1);
    k = 0;
    while (RX_BUSY !== 1'b0 && k < 30) begin @(negedge baudclk); k++; end
    chk("glitch_busy_lo", RX_BUSY, 0);
    repeat (2*OS) align();
    chk("glitch_no_stat", n_stat, 3);
    chk("glitch_no_ferr", n_ferr, 0);

    // Bad stop followed by a long break, then recovery
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40*OS) align();
    chk("break_busy", RX_BUSY, 1);
    UART_RX = 1'b1;
    repeat (2*OS) align();
    chk("break_one_ferr", n_ferr, 1);
    chk("break_data_kept", RX_DATA, 8'hFF);
    chk("break_idle", RX_BUSY, 0);
    send_frame(8'h11, 1'b1, 1'b0);
    repeat (2*OS) align();
    chk("after_break_data", RX_DATA, 8'h11);

    // Reset in the middle of data bit 4
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b5a[i]);
    UART_RX = b5a[4];
    repeat (OS/2) align();
    reset_n = 1'b0;
    repeat (3) align();
    chk("midrst_data", RX_DATA, 8'h00);
    chk("midrst_busy", RX_BUSY, 0);
    UART_RX = 1'b1;
    reset_n = 1'b1;
    repeat (2*OS) align();
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (2*OS) align();
    chk("midrst_next", RX_DATA, 8'hC3);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (2*OS) align();
    chk("par_bad_data_kept", RX_DATA, 8'hC3);
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (2*OS) align();
    chk("par_good_data", RX_DATA, 8'h07);
    chk("par_good_latency", stat_at - busy_rise, 168);
`endif

    repeat (4) align();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
